exp_share_arbiter: RTL

Round-robin scheduler that shares one `exponential` unit between up to four requesters. It accepts one request at a time, sequences the unit's `start`/`done` handshake, and returns the result tagged with the requester's index. It sits between the client blocks and the single `exponential` instance; it is the only driver of that unit's `x` and `start` inputs.

---
 rtl/exp_share_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/exp_share_arbiter.sv
// exp_share_arbiter: round-robin front end that shares one exponential unit
// between up to four requesters. One request is in flight at a time; the FSM
// sequences the unit's start/done handshake and returns the result tagged
// with the owner's index.
// Optional watchdog on the WAIT state: define EXP_ARB_TIMEOUT_EN.
module exp_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          exp_x,
    output logic                 exp_start,
    input  logic                 exp_done,
    input  logic [1:0]           exp_intpart,
    input  logic [15:0]          exp_fracpart,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [1:0]           rsp_intpart,
    output logic [15:0]          rsp_fracpart,
    output logic                 rsp_err,
    output logic                 busy
);

    // Elaboration-time sanity on the configuration.
    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("exp_share_arbiter: NREQ must be 2..4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("exp_share_arbiter: TIMEOUT must be 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_ptr;
    logic [15:0]     r_exp_x;
    logic [1:0]      r_id;
    logic [1:0]      r_int;
    logic [15:0]     r_frac;

    logic            w_gnt_vld;
    logic [1:0]      w_gnt_id;
    logic [NREQ-1:0] w_gnt_oh;
    logic [15:0]     w_gnt_x;
    logic [2:0]      w_scan;
    logic [2:0]      w_ptr_inc;
    logic [1:0]      w_ptr_nxt;
    logic            w_timeout;

`ifdef EXP_ARB_TIMEOUT_EN
    logic [7:0]      r_cnt;
    logic            r_err;
`endif

    // Round-robin pick: first valid requester at or after r_ptr, wrapping.
    // Scanning from the far end lets the nearest offset overwrite the others.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 2'd0;
        w_scan    = 3'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_ptr} + 3'(k);
            if (w_scan >= 3'(NREQ))
                w_scan = w_scan - 3'(NREQ);
            if (req_valid[w_scan[1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_scan[1:0];
            end
        end
    end

    // Winner's one-hot mask, operand mux and the pointer just past it.
    always_comb begin
        w_gnt_oh = '0;
        w_gnt_oh[w_gnt_id] = w_gnt_vld;
        w_gnt_x  = 16'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_id == 2'(k))
                w_gnt_x = req_x[16*k +: 16];
        end
        w_ptr_inc = {1'b0, w_gnt_id} + 3'd1;
        w_ptr_nxt = (w_ptr_inc >= 3'(NREQ)) ? 2'd0 : w_ptr_inc[1:0];
    end

`ifdef EXP_ARB_TIMEOUT_EN
    // Counter sits at 0 on the first WAIT cycle, so the limit trips on the
    // TIMEOUT-th WAIT cycle.
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; exp_done matters only in WAIT so a stale done is dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (exp_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= 2'd0;
            r_exp_x <= 16'd0;
            r_id    <= 2'd0;
            r_int   <= 2'd0;
            r_frac  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_exp_x <= w_gnt_x;
                        r_id    <= w_gnt_id;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                S_WAIT: begin
                    if (exp_done) begin
                        r_int  <= exp_intpart;
                        r_frac <= exp_fracpart;
                    end else if (w_timeout) begin
                        r_int  <= 2'd0;
                        r_frac <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EXP_ARB_TIMEOUT_EN
    // Watchdog counter and the sticky error flag it raises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (w_gnt_vld) r_err <= 1'b0;
                S_START: r_cnt <= 8'd0;
                S_WAIT: begin
                    if (!exp_done) begin
                        if (w_timeout)
                            r_err <= 1'b1;
                        else
                            r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    // Status outputs decode straight from the state register, so reset
    // clears them without waiting for a clock edge. req_ready is gated by
    // rst because it also depends on the live req_valid inputs.
    assign req_ready    = (rst && r_state == S_IDLE) ? w_gnt_oh : '0;
    assign exp_start    = (r_state == S_START);
    assign rsp_valid    = (r_state == S_RESP);
    assign busy         = (r_state != S_IDLE);
    assign exp_x        = r_exp_x;
    assign rsp_id       = r_id;
    assign rsp_intpart  = r_int;
    assign rsp_fracpart = r_frac;

endmodule
